moving_avg_mc: RTL and testbench

MOVING_AVG_MC -- requirements
Module: moving_avg_mc

---
 rtl/moving_avg_mc.sv | 150 +++++++++++++++
 tb/tb_moving_avg_mc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/moving_avg_mc.sv
// Multi-channel moving-average accelerator: per-channel circular sample window
// with a running sum, driven by a start/done command handshake.
module moving_avg_mc #(
    parameter int SAMPLE_W   = 16,
    parameter int LOG2_DEPTH = 4,
    parameter int NUM_CH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    localparam int DEPTH  = 2 ** LOG2_DEPTH;
    localparam int SUM_W  = SAMPLE_W + LOG2_DEPTH;
    localparam int FILL_W = LOG2_DEPTH + 1;
    localparam int CH_IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE, S_DONE} state_t;
    typedef enum logic [1:0] {OP_PUSH, OP_CLEAR, OP_READ, OP_STATUS} op_t;

    state_t              state;
    op_t                 lat_op;
    logic                lat_zext;
    logic [1:0]          lat_ch;
    logic [SAMPLE_W-1:0] lat_sample;
    logic [SAMPLE_W-1:0] oldest;

    logic [SAMPLE_W-1:0]   buf_mem [NUM_CH][DEPTH];
    logic [SUM_W-1:0]      sum_r   [NUM_CH];
    logic [LOG2_DEPTH-1:0] ptr_r   [NUM_CH];
    logic [FILL_W-1:0]     fill_r  [NUM_CH];

    logic                ch_ok;
    logic [CH_IW-1:0]    ch_idx;
    logic [SUM_W-1:0]    cur_sum;
    logic [FILL_W-1:0]   cur_fill;
    logic [SUM_W-1:0]    sample_ext;
    logic [SUM_W-1:0]    oldest_ext;
    logic [SUM_W-1:0]    push_sum;
    logic [SUM_W-1:0]    avg_sum;
    logic [SAMPLE_W-1:0] avg;
    logic [31:0]         avg_word;
    logic [31:0]         res_next;

    logic unused_inputs;
    assign unused_inputs = ^{dataa[31:SAMPLE_W], datab[31:10], datab[7:3]};

    assign ch_ok  = int'(lat_ch) < NUM_CH;
    assign ch_idx = lat_ch[CH_IW-1:0];

    always_comb begin
        cur_sum    = '0;
        cur_fill   = '0;
        if (ch_ok) begin
            cur_sum  = sum_r[ch_idx];
            cur_fill = fill_r[ch_idx];
        end
        sample_ext = {{LOG2_DEPTH{lat_sample[SAMPLE_W-1]}}, lat_sample};
        oldest_ext = {{LOG2_DEPTH{oldest[SAMPLE_W-1]}}, oldest};
        push_sum   = cur_sum - oldest_ext + sample_ext;
        avg_sum    = (lat_op == OP_PUSH) ? push_sum : cur_sum;
        // Dropping the low LOG2_DEPTH bits is an arithmetic shift (floor toward -inf).
        avg        = avg_sum[SUM_W-1:LOG2_DEPTH];
        avg_word   = lat_zext ? {{(32-SAMPLE_W){1'b0}}, avg}
                              : {{(32-SAMPLE_W){avg[SAMPLE_W-1]}}, avg};
        res_next   = '0;
        if (ch_ok) begin
            case (lat_op)
                OP_PUSH, OP_READ: res_next = avg_word;
                OP_STATUS:        res_next = {{(32-FILL_W){1'b0}}, cur_fill};
                default:          res_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            result     <= '0;
            lat_op     <= OP_PUSH;
            lat_zext   <= 1'b0;
            lat_ch     <= '0;
            lat_sample <= '0;
            oldest     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                sum_r[i]  <= '0;
                ptr_r[i]  <= '0;
                fill_r[i] <= '0;
            end
        end else if (clk_en) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lat_sample <= dataa[SAMPLE_W-1:0];
                        lat_op     <= op_t'(datab[1:0]);
                        lat_zext   <= datab[2];
                        lat_ch     <= datab[9:8];
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (ch_ok && cur_fill == FILL_W'(DEPTH))
                        oldest <= buf_mem[ch_idx][ptr_r[ch_idx]];
                    else
                        oldest <= '0;
                    state <= S_UPDATE;
                end
                S_UPDATE: begin
                    result <= res_next;
                    done   <= 1'b1;
                    state  <= S_DONE;
                    if (ch_ok) begin
                        case (lat_op)
                            OP_PUSH: begin
                                sum_r[ch_idx] <= push_sum;
                                ptr_r[ch_idx] <= ptr_r[ch_idx] + LOG2_DEPTH'(1);
                                if (cur_fill != FILL_W'(DEPTH))
                                    fill_r[ch_idx] <= cur_fill + FILL_W'(1);
                            end
                            OP_CLEAR: begin
                                sum_r[ch_idx]  <= '0;
                                ptr_r[ch_idx]  <= '0;
                                fill_r[ch_idx] <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sample RAM is not reset; an async reset drops state out of S_UPDATE first.
    always_ff @(posedge clk) begin
        if (clk_en && state == S_UPDATE && lat_op == OP_PUSH && ch_ok)
            buf_mem[ch_idx][ptr_r[ch_idx]] <= lat_sample;
    end

endmodule

// File: tb/tb_moving_avg_mc.sv
// Scoreboard bench for moving_avg_mc: a behavioural model queues expected
// results on each command and a done monitor pops and compares them.
module tb_moving_avg_mc;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;
    logic [31:0] result_b;
    logic        done_b;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int done_b_cnt = 0;
    logic done_prev = 1'b0;
    logic done_b_prev = 1'b0;
    logic [31:0] last_result = '0;
    logic [31:0] exp_q[$];

    int msum[4];
    int mptr[4];
    int mfill[4];
    int mbuf[4][16];

    moving_avg_mc #(.SAMPLE_W(16), .LOG2_DEPTH(4), .NUM_CH(4)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
        .dataa(dataa), .datab(datab), .result(result), .done(done)
    );

    // Narrow instance: channels 2 and 3 are out of range here.
    moving_avg_mc #(.SAMPLE_W(16), .LOG2_DEPTH(4), .NUM_CH(2)) dut_b (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
        .dataa(dataa), .datab(datab), .result(result_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done && !done_prev) begin
            done_cnt++;
            last_result = result;
            if (exp_q.size() == 0)
                check("spurious_done", 32'd1, 32'd0);
            else
                check("result", result, exp_q.pop_front());
        end
        if (done_b && !done_b_prev)
            done_b_cnt++;
        done_prev   = done;
        done_b_prev = done_b;
    end

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            msum[c]  = 0;
            mptr[c]  = 0;
            mfill[c] = 0;
        end
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic zext,
                                          input logic [1:0] ch, input logic [15:0] smp);
        logic signed [15:0] ss;
        int s, old, avg;
        ss = smp;
        s  = ss;
        case (op)
            2'b00: begin
                old = (mfill[ch] == 16) ? mbuf[ch][mptr[ch]] : 0;
                msum[ch] = msum[ch] - old + s;
                mbuf[ch][mptr[ch]] = s;
                mptr[ch] = (mptr[ch] + 1) % 16;
                if (mfill[ch] < 16) mfill[ch]++;
            end
            2'b01: begin
                msum[ch]  = 0;
                mptr[ch]  = 0;
                mfill[ch] = 0;
                return 32'h0;
            end
            2'b11: return 32'(mfill[ch]);
            default: ;
        endcase
        avg = msum[ch] >>> 4;
        return zext ? (32'(avg) & 32'h0000FFFF) : 32'(avg);
    endfunction

    function automatic logic [31:0] cmd_word(input logic [1:0] op, input logic zext, input logic [1:0] ch);
        logic [31:0] w;
        w = $urandom();
        w[1:0] = op;
        w[2]   = zext;
        w[9:8] = ch;
        return w;
    endfunction

    task automatic cmd(input logic [1:0] op, input logic zext, input logic [1:0] ch, input logic [15:0] smp);
        int base;
        int n;
        exp_q.push_back(model(op, zext, ch, smp));
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        dataa = {16'hA5C3, smp};
        datab = cmd_word(op, zext, ch);
        @(negedge clk);
        start = 1'b0;
        dataa = $urandom();
        datab = $urandom();
        n = 0;
        while (done_cnt == base && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt == base) begin
            check("done_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        int base;
        int base_b;
        model_reset();
        reset  = 1'b0;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        datab  = '0;
        #1;
        check("rst_result", result, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Fill ch0 with 0x10, then wrap with 0x20 and partially back with 0x10.
        cmd(2'b00, 1'b0, 2'd0, 16'h0010);
        check("first_push", last_result, 32'h00000001);
        for (int i = 1; i < 16; i++) cmd(2'b00, 1'b0, 2'd0, 16'h0010);
        check("ch0_full", last_result, 32'h00000010);
        cmd(2'b11, 1'b0, 2'd0, 16'h0);
        check("ch0_status", last_result, 32'd16);
        for (int i = 0; i < 16; i++) cmd(2'b00, 1'b0, 2'd0, 16'h0020);
        check("wrap_last", last_result, 32'h00000020);
        for (int i = 0; i < 8; i++) cmd(2'b00, 1'b0, 2'd0, 16'h0010);
        check("wrap_half", last_result, 32'h00000018);

        // Negative samples on ch1, both extension modes.
        cmd(2'b00, 1'b0, 2'd1, 16'hFFF0);
        check("neg_floor", last_result, 32'hFFFFFFFF);
        for (int i = 1; i < 16; i++) cmd(2'b00, 1'b0, 2'd1, 16'hFFF0);
        check("neg_sext", last_result, 32'hFFFFFFF0);
        cmd(2'b00, 1'b1, 2'd1, 16'hFFF0);
        check("neg_zext", last_result, 32'h0000FFF0);

        // Isolation and clear across ch2/ch3.
        cmd(2'b00, 1'b0, 2'd3, 16'h0040);
        cmd(2'b00, 1'b0, 2'd2, 16'h0100);
        cmd(2'b01, 1'b0, 2'd2, 16'h0);
        cmd(2'b10, 1'b0, 2'd2, 16'h0);
        check("clear_read", last_result, 32'h0);
        cmd(2'b10, 1'b0, 2'd3, 16'h0);
        check("ch3_intact", last_result, 32'h00000004);
        cmd(2'b10, 1'b0, 2'd1, 16'h0);
        check("oor_prev_nonzero", result_b, 32'hFFFFFFF0);
        base_b = done_b_cnt;
        cmd(2'b10, 1'b0, 2'd3, 16'h0);
        check("oor_result", result_b, 32'h0);
        check("oor_done", 32'(done_b_cnt - base_b), 32'd1);

        // Clock-enable gaps and a second start while busy.
        exp_q.push_back(model(2'b10, 1'b0, 2'd0, 16'h0));
        base = done_cnt;
        @(negedge clk); start = 1'b1; clk_en = 1'b1; datab = cmd_word(2'b10, 1'b0, 2'd0);
        @(negedge clk); start = 1'b0; clk_en = 1'b0;
        check("hs_c1", {31'b0, done}, 32'h0);
        @(negedge clk); start = 1'b1; clk_en = 1'b1; datab = cmd_word(2'b11, 1'b0, 2'd1);
        check("hs_c2", {31'b0, done}, 32'h0);
        @(negedge clk); start = 1'b0; clk_en = 1'b0;
        check("hs_c3", {31'b0, done}, 32'h0);
        @(negedge clk); clk_en = 1'b1;
        check("hs_c4", {31'b0, done}, 32'h0);
        @(negedge clk); clk_en = 1'b0;
        check("hs_done", {31'b0, done}, 32'h1);
        @(negedge clk); clk_en = 1'b1;
        check("hs_hold", {31'b0, done}, 32'h1);
        @(negedge clk);
        check("hs_drop", {31'b0, done}, 32'h0);
        repeat (6) @(negedge clk);
        #1;
        check("hs_one_done", 32'(done_cnt - base), 32'd1);

        // Random traffic across all channels and opcodes.
        for (int i = 0; i < 60; i++)
            cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 16'($urandom()));

        // Reset while the command sits in UPDATE.
        base = done_cnt;
        @(negedge clk); start = 1'b1; dataa = 32'h000007FF; datab = cmd_word(2'b00, 1'b0, 2'd2);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_result", result, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - base), 32'd0);
        cmd(2'b11, 1'b0, 2'd2, 16'h0);
        check("abort_status", last_result, 32'h0);
        cmd(2'b00, 1'b0, 2'd0, 16'h0010);
        check("fresh_push", last_result, 32'h00000001);

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
